// File: rtl/panel_cmd_sequencer.sv
// Front-panel command sequencer: operator selects clear/write/read, enters fields
// nibble by nibble, then the block runs valid/ready transactions to the memory controller.
module panel_cmd_sequencer #(
    parameter int          ADDR_W   = 25,
    parameter int          DATA_W   = 16,
    parameter int          NSW      = 4,
    parameter logic [31:0] CLR_LAST = 32'((64'd1 << ADDR_W) - 64'd1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        button,
    input  logic [NSW-1:0]    sw,
    input  logic              mem_ready,
    input  logic              mem_done,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              cmd_valid,
    output logic [1:0]        mem_cmd,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wr_data,
    output logic              busy,
    output logic [31:0]       disp_data
);
    localparam int W  = 4 * NSW;
    localparam int AP = (ADDR_W + W - 1) / W;
    localparam int DP = (DATA_W + W - 1) / W;
    localparam logic [3:0]        LAST_RD   = 4'(AP - 1);
    localparam logic [3:0]        LAST_WR   = 4'(AP + DP - 1);
    localparam logic [3:0]        LAST_SHOW = 4'(DP - 1);
    localparam logic [3:0]        FIRST_DP  = 4'(AP);
    localparam logic [23:0]       WIN_MASK  = 24'((64'd1 << W) - 64'd1);
    localparam logic [ADDR_W-1:0] CLR_END   = CLR_LAST[ADDR_W-1:0];

    typedef enum logic [2:0] {
        S_SELECT, S_ENTRY, S_ISSUE, S_WAIT, S_SHOW, S_CLR_ISSUE, S_CLR_WAIT
    } state_t;

    // Increment each rising nibble of the page modulo its in-field width; no carry between nibbles.
    function automatic logic [63:0] incPage(input logic [63:0] f, input int base, input int fw,
                                            input logic [NSW-1:0] rise);
        logic [63:0] v;
        logic [3:0]  n;
        int          pos;
        v = f;
        for (int i = 0; i < NSW; i++) begin
            pos = base + 4 * i;
            if (rise[i] && pos >= 0 && pos < fw) begin
                n = 4'(v >> pos) + 4'd1;
                for (int k = 0; k < 4; k++)
                    if (pos + k < fw) v[6'(pos + k)] = n[k];
            end
        end
        return v;
    endfunction

    function automatic logic [23:0] pageWin(input logic [63:0] f, input int p);
        return 24'(f >> (p * W)) & WIN_MASK;
    endfunction

    state_t              r_state;
    logic [1:0]          r_cmd;
    logic [3:0]          r_page;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_data;
    logic [DATA_W-1:0]   r_rd;
    logic                r_abort_pend;
    logic [1:0]          r_btn, r_btn_prev;
    logic [NSW-1:0]      r_sw, r_sw_prev;
    logic                r_cmd_valid, r_busy;
    logic [1:0]          r_mem_cmd;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wr_data;

    logic                w_abort, w_next, w_exec;
    logic [NSW-1:0]      w_sw_rise;
    logic [3:0]          w_last_entry;
    logic [ADDR_W-1:0]   w_addr_inc;
    logic [DATA_W-1:0]   w_data_inc;
    logic [1:0]          w_phase;
    logic [3:0]          w_page_disp;
    logic [23:0]         w_window;

    assign w_abort      = (r_btn == 2'b11) && (r_btn_prev != 2'b11);
    assign w_next       = r_btn[0] & ~r_btn_prev[0] & ~w_abort;
    assign w_exec       = r_btn[1] & ~r_btn_prev[1] & ~w_abort;
    assign w_sw_rise    = r_sw & ~r_sw_prev;
    assign w_last_entry = (r_cmd == 2'b01) ? LAST_WR : LAST_RD;
    assign w_addr_inc   = ADDR_W'(incPage(64'(r_addr), int'(r_page) * W, ADDR_W, w_sw_rise));
    assign w_data_inc   = DATA_W'(incPage(64'(r_data), (int'(r_page) - AP) * W, DATA_W, w_sw_rise));

    always_comb begin
        w_phase     = 2'd2;
        w_page_disp = 4'd0;
        w_window    = 24'd0;
        case (r_state)
            S_SELECT: w_phase = 2'd0;
            S_ENTRY: begin
                w_phase     = 2'd1;
                w_page_disp = r_page;
                w_window    = (r_page < FIRST_DP) ? pageWin(64'(r_addr), int'(r_page))
                                                  : pageWin(64'(r_data), int'(r_page) - AP);
            end
            S_SHOW: begin
                w_phase     = 2'd3;
                w_page_disp = r_page;
                w_window    = pageWin(64'(r_rd), int'(r_page));
            end
            default: w_phase = 2'd2;
        endcase
    end

    assign cmd_valid   = r_cmd_valid;
    assign mem_cmd     = r_mem_cmd;
    assign mem_addr    = r_mem_addr;
    assign mem_wr_data = r_mem_wr_data;
    assign busy        = r_busy;
    assign disp_data   = {r_cmd, w_phase, w_page_disp, w_window};

    // A transfer wins over an abort sampled in the same cycle: the controller already owns it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_SELECT;
            r_cmd         <= 2'b00;
            r_page        <= 4'd0;
            r_addr        <= '0;
            r_data        <= '0;
            r_rd          <= '0;
            r_abort_pend  <= 1'b0;
            r_btn         <= 2'b00;
            r_btn_prev    <= 2'b00;
            r_sw          <= '0;
            r_sw_prev     <= '0;
            r_cmd_valid   <= 1'b0;
            r_busy        <= 1'b0;
            r_mem_cmd     <= 2'b11;
            r_mem_addr    <= '0;
            r_mem_wr_data <= '0;
        end else begin
            r_btn      <= button;
            r_btn_prev <= r_btn;
            r_sw       <= sw;
            r_sw_prev  <= r_sw;
            case (r_state)
                S_SELECT: begin
                    r_abort_pend <= 1'b0;
                    if (w_exec) begin
                        r_addr <= '0;
                        r_data <= '0;
                        r_page <= 4'd0;
                        if (r_cmd == 2'b00) begin
                            r_state       <= S_CLR_ISSUE;
                            r_cmd_valid   <= 1'b1;
                            r_mem_cmd     <= 2'b00;
                            r_mem_addr    <= '0;
                            r_mem_wr_data <= '0;
                            r_busy        <= 1'b1;
                        end else begin
                            r_state <= S_ENTRY;
                        end
                    end else if (w_next) begin
                        r_cmd <= (r_cmd == 2'b10) ? 2'b00 : r_cmd + 2'd1;
                    end
                end
                S_ENTRY: begin
                    if (w_abort) begin
                        r_state <= S_SELECT;
                        r_page  <= 4'd0;
                    end else if (w_exec) begin
                        if (r_page == w_last_entry) begin
                            r_state       <= S_ISSUE;
                            r_cmd_valid   <= 1'b1;
                            r_mem_cmd     <= r_cmd;
                            r_mem_addr    <= r_addr;
                            r_mem_wr_data <= (r_cmd == 2'b01) ? r_data : '0;
                            r_busy        <= 1'b1;
                        end else begin
                            r_page <= r_page + 4'd1;
                        end
                    end else if (r_page < FIRST_DP) begin
                        r_addr <= w_addr_inc;
                    end else begin
                        r_data <= w_data_inc;
                    end
                end
                S_ISSUE, S_CLR_ISSUE: begin
                    if (mem_ready) begin
                        r_state      <= (r_state == S_ISSUE) ? S_WAIT : S_CLR_WAIT;
                        r_cmd_valid  <= 1'b0;
                        r_mem_cmd    <= 2'b11;
                        r_abort_pend <= w_abort;
                    end else if (w_abort) begin
                        r_state     <= S_SELECT;
                        r_cmd_valid <= 1'b0;
                        r_mem_cmd   <= 2'b11;
                        r_busy      <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (mem_done) begin
                        r_busy       <= 1'b0;
                        r_abort_pend <= 1'b0;
                        if (r_abort_pend || w_abort || r_cmd != 2'b10) begin
                            r_state <= S_SELECT;
                        end else begin
                            r_rd    <= mem_rd_data;
                            r_page  <= 4'd0;
                            r_state <= S_SHOW;
                        end
                    end else if (w_abort) begin
                        r_abort_pend <= 1'b1;
                    end
                end
                S_SHOW: begin
                    if (w_abort) begin
                        r_state <= S_SELECT;
                        r_page  <= 4'd0;
                    end else if (w_exec) begin
                        if (r_page == LAST_SHOW) begin
                            r_state <= S_SELECT;
                            r_page  <= 4'd0;
                        end else begin
                            r_page <= r_page + 4'd1;
                        end
                    end
                end
                S_CLR_WAIT: begin
                    if (mem_done) begin
                        if (r_abort_pend || w_abort || r_addr == CLR_END) begin
                            r_state      <= S_SELECT;
                            r_busy       <= 1'b0;
                            r_abort_pend <= 1'b0;
                        end else begin
                            r_addr        <= r_addr + 1'b1;
                            r_state       <= S_CLR_ISSUE;
                            r_cmd_valid   <= 1'b1;
                            r_mem_cmd     <= 2'b00;
                            r_mem_addr    <= r_addr + 1'b1;
                            r_mem_wr_data <= '0;
                        end
                    end else if (w_abort) begin
                        r_abort_pend <= 1'b1;
                    end
                end
                default: r_state <= S_SELECT;
            endcase
        end
    end
endmodule

// File: tb/tb_panel_cmd_sequencer.sv
// Bench for panel_cmd_sequencer: drives panel buttons/switches, models the memory
// controller and scoreboards every transfer against expected transactions.
module tb_panel_cmd_sequencer;
    typedef struct {
        logic [1:0]  cmd;
        logic [24:0] addr;
        logic [15:0] data;
    } txn_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  button;
    logic [3:0]  sw;
    logic        mem_ready = 1'b0;
    logic        mem_done = 1'b0;
    logic [15:0] mem_rd_data = 16'd0;
    logic        cmd_valid;
    logic [1:0]  mem_cmd;
    logic [24:0] mem_addr;
    logic [15:0] mem_wr_data;
    logic        busy;
    logic [31:0] disp_data;

    int          checks = 0;
    int          errors = 0;
    logic        holdReady = 1'b0;
    int          doneDelay = 0;
    logic [15:0] rdValue = 16'd0;
    logic        pendDone = 1'b0;
    int          doneWait = 0;
    txn_t        monTxn;
    txn_t        obsQ[$];
    txn_t        expQ[$];
    txn_t        e, o;

    panel_cmd_sequencer #(.ADDR_W(25), .DATA_W(16), .NSW(4), .CLR_LAST(32'd3)) dut (
        .clk(clk), .rst_n(rst_n), .button(button), .sw(sw),
        .mem_ready(mem_ready), .mem_done(mem_done), .mem_rd_data(mem_rd_data),
        .cmd_valid(cmd_valid), .mem_cmd(mem_cmd), .mem_addr(mem_addr),
        .mem_wr_data(mem_wr_data), .busy(busy), .disp_data(disp_data)
    );

    always #5 clk = ~clk;

    // Memory controller model: records transfers and answers each with a delayed done pulse.
    always @(negedge clk) begin
        mem_ready = !holdReady;
        if (!rst_n) begin
            mem_done = 1'b0;
            pendDone = 1'b0;
        end else begin
            mem_done = 1'b0;
            if (pendDone) begin
                if (doneWait == 0) begin
                    mem_done    = 1'b1;
                    mem_rd_data = rdValue;
                    pendDone    = 1'b0;
                end else begin
                    doneWait--;
                end
            end
            if (cmd_valid && mem_ready) begin
                monTxn.cmd  = mem_cmd;
                monTxn.addr = mem_addr;
                monTxn.data = mem_wr_data;
                obsQ.push_back(monTxn);
                pendDone = 1'b1;
                doneWait = doneDelay;
            end
        end
    end

    task pressButton(input logic [1:0] b);
        @(negedge clk);
        button = b;
        repeat (2) @(negedge clk);
        button = 2'b00;
        repeat (3) @(negedge clk);
    endtask

    task pulseSw(input int idx, input int count);
        for (int c = 0; c < count; c++) begin
            @(negedge clk);
            sw = 4'(1 << idx);
            @(negedge clk);
            sw = 4'd0;
        end
        repeat (2) @(negedge clk);
    endtask

    task pushExp(input logic [1:0] c, input logic [24:0] a, input logic [15:0] d);
        txn_t t;
        t.cmd = c; t.addr = a; t.data = d;
        expQ.push_back(t);
    endtask

    task test_reset;
        rst_n = 1'b0; button = 2'b00; sw = 4'd0;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (cmd_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", cmd_valid); end
        checks++; if (mem_cmd !== 2'b11) begin errors++; $display("[TB] FAIL reset_cmd: got %b expected 11", mem_cmd); end
        checks++; if (mem_addr !== 25'd0) begin errors++; $display("[TB] FAIL reset_addr: got %h expected 0", mem_addr); end
        checks++; if (mem_wr_data !== 16'd0) begin errors++; $display("[TB] FAIL reset_wdata: got %h expected 0", mem_wr_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (disp_data !== 32'd0) begin errors++; $display("[TB] FAIL reset_disp: got %h expected 0", disp_data); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task test_write;
        pressButton(2'b01);
        #1;
        checks++; if (disp_data[31:30] !== 2'b01) begin errors++; $display("[TB] FAIL write_sel: got %b expected 01", disp_data[31:30]); end
        pressButton(2'b10);
        #1;
        checks++; if (disp_data[29:24] !== 6'b01_0000) begin errors++; $display("[TB] FAIL write_entry: got %b expected 010000", disp_data[29:24]); end
        pulseSw(0, 5); pulseSw(1, 4); pulseSw(2, 3); pulseSw(3, 2);
        #1;
        checks++; if (disp_data[23:0] !== 24'h002345) begin errors++; $display("[TB] FAIL write_page0: got %h expected 002345", disp_data[23:0]); end
        pressButton(2'b10);
        #1;
        checks++; if (disp_data[27:24] !== 4'd1) begin errors++; $display("[TB] FAIL write_page1: got %0d expected 1", disp_data[27:24]); end
        pulseSw(0, 1);
        pressButton(2'b10);
        pulseSw(3, 10);
        #1;
        checks++; if (disp_data[23:0] !== 24'h00A000) begin errors++; $display("[TB] FAIL write_dpage: got %h expected 00A000", disp_data[23:0]); end
        pushExp(2'b01, 25'h0012345, 16'hA000);
        pressButton(2'b10);
        repeat (6) @(negedge clk);
        #1;
        checks++; if ({cmd_valid, mem_cmd, busy, disp_data[29:28]} !== 6'b0_11_0_00) begin
            errors++; $display("[TB] FAIL write_idle: got %b expected 011000", {cmd_valid, mem_cmd, busy, disp_data[29:28]}); end
        checks++; if (obsQ.size() !== expQ.size()) begin errors++; $display("[TB] FAIL write_count: got %0d expected %0d", obsQ.size(), expQ.size()); end
        while (expQ.size() > 0 && obsQ.size() > 0) begin
            e = expQ.pop_front(); o = obsQ.pop_front();
            checks++;
            if ({o.cmd, o.addr, o.data} !== {e.cmd, e.addr, e.data}) begin
                errors++; $display("[TB] FAIL write_txn: got %b/%h/%h expected %b/%h/%h", o.cmd, o.addr, o.data, e.cmd, e.addr, e.data); end
        end
        expQ.delete(); obsQ.delete();
    endtask

    task test_wrap;
        pressButton(2'b10);
        pulseSw(0, 17);
        #1;
        checks++; if (disp_data[23:0] !== 24'h000001) begin errors++; $display("[TB] FAIL wrap_nib0: got %h expected 000001", disp_data[23:0]); end
        pressButton(2'b10);
        pulseSw(2, 3);
        #1;
        checks++; if (disp_data[23:0] !== 24'h000100) begin errors++; $display("[TB] FAIL wrap_bit24: got %h expected 000100", disp_data[23:0]); end
        pulseSw(3, 2);
        #1;
        checks++; if (disp_data[23:0] !== 24'h000100) begin errors++; $display("[TB] FAIL wrap_beyond: got %h expected 000100", disp_data[23:0]); end
        pushExp(2'b01, 25'h1000001, 16'h0000);
        pressButton(2'b10);
        pressButton(2'b10);
        repeat (6) @(negedge clk);
        checks++; if (obsQ.size() !== expQ.size()) begin errors++; $display("[TB] FAIL wrap_count: got %0d expected %0d", obsQ.size(), expQ.size()); end
        while (expQ.size() > 0 && obsQ.size() > 0) begin
            e = expQ.pop_front(); o = obsQ.pop_front();
            checks++;
            if ({o.cmd, o.addr, o.data} !== {e.cmd, e.addr, e.data}) begin
                errors++; $display("[TB] FAIL wrap_txn: got %b/%h/%h expected %b/%h/%h", o.cmd, o.addr, o.data, e.cmd, e.addr, e.data); end
        end
        expQ.delete(); obsQ.delete();
    endtask

    task test_read_backpressure;
        int n;
        pressButton(2'b01);
        #1;
        checks++; if (disp_data[31:30] !== 2'b10) begin errors++; $display("[TB] FAIL read_sel: got %b expected 10", disp_data[31:30]); end
        pressButton(2'b10);
        pulseSw(1, 1);
        pressButton(2'b10);
        holdReady = 1'b1;
        pushExp(2'b10, 25'h0000010, 16'h0000);
        pressButton(2'b10);
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++;
            if ({cmd_valid, mem_cmd, mem_addr, busy} !== {1'b1, 2'b10, 25'h0000010, 1'b1}) begin
                errors++; $display("[TB] FAIL read_hold: got %b/%b/%h/%b expected 1/10/0000010/1", cmd_valid, mem_cmd, mem_addr, busy); end
            @(negedge clk);
        end
        checks++; if (obsQ.size() !== 0) begin errors++; $display("[TB] FAIL read_early: got %0d transfers expected 0", obsQ.size()); end
        rdValue = 16'hBEEF;
        holdReady = 1'b0;
        n = 0;
        #1;
        while (mem_done !== 1'b1 && n < 50) begin
            @(negedge clk); #1; n++;
        end
        checks++; if (mem_done !== 1'b1) begin errors++; $display("[TB] FAIL read_done: got %b expected 1 within 50 cycles", mem_done); end
        @(negedge clk); #1;
        checks++; if (disp_data[29:24] !== 6'b11_0000) begin errors++; $display("[TB] FAIL read_show: got %b expected 110000", disp_data[29:24]); end
        checks++; if (disp_data[23:0] !== 24'h00BEEF) begin errors++; $display("[TB] FAIL read_data: got %h expected 00BEEF", disp_data[23:0]); end
        checks++; if (obsQ.size() !== expQ.size()) begin errors++; $display("[TB] FAIL read_count: got %0d expected %0d", obsQ.size(), expQ.size()); end
        while (expQ.size() > 0 && obsQ.size() > 0) begin
            e = expQ.pop_front(); o = obsQ.pop_front();
            checks++;
            if ({o.cmd, o.addr} !== {e.cmd, e.addr}) begin
                errors++; $display("[TB] FAIL read_txn: got %b/%h expected %b/%h", o.cmd, o.addr, e.cmd, e.addr); end
        end
        expQ.delete(); obsQ.delete();
        pressButton(2'b10);
        #1;
        checks++; if (disp_data[31:28] !== 4'b10_00) begin errors++; $display("[TB] FAIL read_exit: got %b expected 1000", disp_data[31:28]); end
    endtask

    task test_clear;
        int n;
        pressButton(2'b01);
        doneDelay = 0;
        for (int a = 0; a < 4; a++) pushExp(2'b00, 25'(a), 16'h0000);
        pressButton(2'b10);
        n = 0;
        #1;
        while (!(obsQ.size() == 4 && busy === 1'b0) && n < 200) begin
            @(negedge clk); #1; n++;
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL clear_busy: got %b expected 0 within 200 cycles", busy); end
        checks++; if (obsQ.size() !== expQ.size()) begin errors++; $display("[TB] FAIL clear_count: got %0d expected %0d", obsQ.size(), expQ.size()); end
        while (expQ.size() > 0 && obsQ.size() > 0) begin
            e = expQ.pop_front(); o = obsQ.pop_front();
            checks++;
            if ({o.cmd, o.addr, o.data} !== {e.cmd, e.addr, e.data}) begin
                errors++; $display("[TB] FAIL clear_txn: got %b/%h/%h expected %b/%h/%h", o.cmd, o.addr, o.data, e.cmd, e.addr, e.data); end
        end
        expQ.delete(); obsQ.delete();
        checks++; if (disp_data[31:28] !== 4'b00_00) begin errors++; $display("[TB] FAIL clear_exit: got %b expected 0000", disp_data[31:28]); end
    endtask

    task test_clear_abort;
        int n;
        doneDelay = 6;
        pushExp(2'b00, 25'd0, 16'h0000);
        pushExp(2'b00, 25'd1, 16'h0000);
        pressButton(2'b10);
        n = 0;
        #1;
        while (obsQ.size() < 2 && n < 100) begin
            @(negedge clk); #1; n++;
        end
        button = 2'b11;
        repeat (3) @(negedge clk);
        button = 2'b00;
        n = 0;
        #1;
        while (busy !== 1'b0 && n < 100) begin
            @(negedge clk); #1; n++;
        end
        repeat (15) @(negedge clk);
        #1;
        checks++; if ({busy, cmd_valid, disp_data[31:28]} !== 6'b0_0_0000) begin
            errors++; $display("[TB] FAIL abort_idle: got %b expected 000000", {busy, cmd_valid, disp_data[31:28]}); end
        checks++; if (obsQ.size() !== expQ.size()) begin errors++; $display("[TB] FAIL abort_count: got %0d expected %0d", obsQ.size(), expQ.size()); end
        while (expQ.size() > 0 && obsQ.size() > 0) begin
            e = expQ.pop_front(); o = obsQ.pop_front();
            checks++;
            if ({o.cmd, o.addr, o.data} !== {e.cmd, e.addr, e.data}) begin
                errors++; $display("[TB] FAIL abort_txn: got %b/%h/%h expected %b/%h/%h", o.cmd, o.addr, o.data, e.cmd, e.addr, e.data); end
        end
        expQ.delete(); obsQ.delete();
        doneDelay = 0;
    endtask

    task test_simultaneous;
        pressButton(2'b01);
        pressButton(2'b10);
        #1;
        checks++; if (disp_data[31:28] !== 4'b01_01) begin errors++; $display("[TB] FAIL simul_entry: got %b expected 0101", disp_data[31:28]); end
        pulseSw(0, 1);
        pressButton(2'b11);
        #1;
        checks++; if (disp_data[31:28] !== 4'b01_00) begin errors++; $display("[TB] FAIL simul_abort: got %b expected 0100", disp_data[31:28]); end
        checks++; if ({busy, cmd_valid} !== 2'b00 || obsQ.size() !== 0) begin
            errors++; $display("[TB] FAIL simul_notxn: got busy=%b valid=%b n=%0d expected 0/0/0", busy, cmd_valid, obsQ.size()); end
        obsQ.delete();
    endtask

    task test_reset_mid_clear;
        int n;
        pressButton(2'b01);
        pressButton(2'b01);
        doneDelay = 20;
        pressButton(2'b10);
        n = 0;
        #1;
        while (obsQ.size() < 1 && n < 50) begin
            @(negedge clk); #1; n++;
        end
        repeat (2) @(negedge clk);
        #1;
        checks++; if ({busy, disp_data[29:28]} !== 3'b1_10) begin errors++; $display("[TB] FAIL midclr_busy: got %b expected 110", {busy, disp_data[29:28]}); end
        rst_n = 1'b0;
        #1;
        checks++; if ({cmd_valid, mem_cmd, busy} !== 4'b0_11_0) begin errors++; $display("[TB] FAIL midclr_ctl: got %b expected 0110", {cmd_valid, mem_cmd, busy}); end
        checks++; if ({mem_addr, mem_wr_data} !== 41'd0) begin errors++; $display("[TB] FAIL midclr_bus: got %h/%h expected 0/0", mem_addr, mem_wr_data); end
        checks++; if (disp_data !== 32'd0) begin errors++; $display("[TB] FAIL midclr_disp: got %h expected 0", disp_data); end
        repeat (3) @(negedge clk);
        obsQ.delete();
        doneDelay = 0;
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        #1;
        checks++; if ({cmd_valid, busy, disp_data} !== 34'd0 || obsQ.size() !== 0) begin
            errors++; $display("[TB] FAIL midclr_after: got %b/%b/%h n=%0d expected 0/0/0 n=0", cmd_valid, busy, disp_data, obsQ.size()); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_wrap();
        test_read_backpressure();
        test_clear();
        test_clear_abort();
        test_simultaneous();
        test_reset_mid_clear();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
